// File: rtl/maj_vote_seq.sv
// Bit-serial triple-redundancy voter: one majority gate, one bit per cycle, LSB first.
// Optional macro MAJ_VOTE_CNT_CLR_EN adds a synchronous cnt_clr input for the fault counters.
module maj_vote_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] ch_a,
   input  logic [WIDTH-1:0] ch_b,
   input  logic [WIDTH-1:0] ch_c,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef MAJ_VOTE_CNT_CLR_EN
   input  logic             cnt_clr,
`endif
   output logic [WIDTH-1:0] voted,
   output logic             err_a,
   output logic             err_b,
   output logic             err_c,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b,
   output logic [CNT_W-1:0] cnt_c,
   output logic             busy
);

   localparam int                 IDX_W    = $clog2(WIDTH);
   localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_VOTE,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] sc;
   logic [IDX_W-1:0] idx;
   logic             bit_m;
   logic             accept;
   logic             xfer;

   function automatic logic maj(input logic a, input logic b, input logic c);
      return (a | b) & (a | c) & (b | c);
   endfunction

   assign bit_m  = maj(sa[0], sb[0], sc[0]);
   assign accept = (state == S_IDLE) && in_valid;
   assign xfer   = (state == S_DONE) && out_ready;

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = S_VOTE;
         end
         S_VOTE: begin
            busy = 1'b1;
            if (idx == IDX_LAST) state_nxt = S_DONE;
         end
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sa    <= '0;
         sb    <= '0;
         sc    <= '0;
         idx   <= '0;
         voted <= '0;
         err_a <= 1'b0;
         err_b <= 1'b0;
         err_c <= 1'b0;
      end else if (accept) begin
         sa    <= ch_a;
         sb    <= ch_b;
         sc    <= ch_c;
         idx   <= '0;
         voted <= '0;
         err_a <= 1'b0;
         err_b <= 1'b0;
         err_c <= 1'b0;
      end else if (state == S_VOTE) begin
         voted[idx] <= bit_m;
         err_a      <= err_a | (sa[0] ^ bit_m);
         err_b      <= err_b | (sb[0] ^ bit_m);
         err_c      <= err_c | (sc[0] ^ bit_m);
         sa         <= sa >> 1;
         sb         <= sb >> 1;
         sc         <= sc >> 1;
         idx        <= idx + IDX_W'(1);
      end
   end

   // Counters advance only on the result handshake and stick at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_a <= '0;
         cnt_b <= '0;
         cnt_c <= '0;
      end
`ifdef MAJ_VOTE_CNT_CLR_EN
      else if (cnt_clr) begin
         cnt_a <= '0;
         cnt_b <= '0;
         cnt_c <= '0;
      end
`endif
      else if (xfer) begin
         if (err_a && cnt_a != CNT_MAX) cnt_a <= cnt_a + CNT_W'(1);
         if (err_b && cnt_b != CNT_MAX) cnt_b <= cnt_b + CNT_W'(1);
         if (err_c && cnt_c != CNT_MAX) cnt_c <= cnt_c + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_maj_vote_seq.sv
// Self-checking bench for maj_vote_seq: directed scenarios plus randomized words
// compared against a word-level majority/counter model.
module tb_maj_vote_seq;

   localparam int WIDTH   = 8;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] ch_a, ch_b, ch_c;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] voted;
   logic             err_a, err_b, err_c;
   logic [CNT_W-1:0] cnt_a, cnt_b, cnt_c;
   logic             busy;
`ifdef MAJ_VOTE_CNT_CLR_EN
   logic             cnt_clr = 1'b0;
`endif

   int n_pass  = 0;
   int n_total = 0;
   int exp_a = 0, exp_b = 0, exp_c = 0;

   always #5 clk = ~clk;

   maj_vote_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ch_a      (ch_a),
      .ch_b      (ch_b),
      .ch_c      (ch_c),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef MAJ_VOTE_CNT_CLR_EN
      .cnt_clr   (cnt_clr),
`endif
      .voted     (voted),
      .err_a     (err_a),
      .err_b     (err_b),
      .err_c     (err_c),
      .cnt_a     (cnt_a),
      .cnt_b     (cnt_b),
      .cnt_c     (cnt_c),
      .busy      (busy)
   );

   // Word-level reference: each voted bit is the value held by at least two channels.
   function automatic logic [WIDTH-1:0] vote_word(input logic [WIDTH-1:0] a, b, c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic [WIDTH+2:0] expect_result(input logic [WIDTH-1:0] a, b, c);
      logic [WIDTH-1:0] v;
      v = vote_word(a, b, c);
      return {v, a != v, b != v, c != v};
   endfunction

   function automatic logic [3*CNT_W-1:0] exp_cnts();
      return {CNT_W'(exp_a), CNT_W'(exp_b), CNT_W'(exp_c)};
   endfunction

   task automatic model_xfer(input logic [WIDTH+2:0] res);
      if (res[2] && exp_a < CNT_MAX) exp_a++;
      if (res[1] && exp_b < CNT_MAX) exp_b++;
      if (res[0] && exp_c < CNT_MAX) exp_c++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      ch_a      = '0;
      ch_b      = '0;
      ch_c      = '0;
      step();
      rst   = 1'b0;
      exp_a = 0;
      exp_b = 0;
      exp_c = 0;
   endtask

   // Presents one word for a single accept edge, then counts edges until out_valid.
   task automatic send_word(input logic [WIDTH-1:0] a, b, c, output int lat);
      ch_a     = a;
      ch_b     = b;
      ch_c     = c;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lat      = 0;
      while (out_valid !== 1'b1 && lat < 4 * WIDTH) begin
         step();
         lat++;
      end
   endtask

   task automatic test_reset();
      apply_reset();
      n_total++;
      if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL reset_hs: got %b expected 100", {in_ready, out_valid, busy});
      else n_pass++;
      n_total++;
      if ({voted, err_a, err_b, err_c} !== '0) $display("FAIL reset_result: got %h expected 0", {voted, err_a, err_b, err_c});
      else n_pass++;
      n_total++;
      if ({cnt_a, cnt_b, cnt_c} !== '0) $display("FAIL reset_cnt: got %h expected 0", {cnt_a, cnt_b, cnt_c});
      else n_pass++;
   endtask

   // Directed words: unanimous, then two channels each disagreeing in one nibble.
   task automatic test_directed();
      int               lat;
      logic [WIDTH-1:0] wa[2] = '{8'hA5, 8'hFF};
      logic [WIDTH-1:0] wb[2] = '{8'hA5, 8'h0F};
      logic [WIDTH-1:0] wc[2] = '{8'hA5, 8'hF0};
      logic [WIDTH+2:0] ex[2] = '{{8'hA5, 3'b000}, {8'hFF, 3'b011}};
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         send_word(wa[i], wb[i], wc[i], lat);
         n_total++;
         if (lat != WIDTH) $display("FAIL directed%0d_latency: got %0d expected %0d", i, lat, WIDTH);
         else n_pass++;
         n_total++;
         if ({voted, err_a, err_b, err_c} !== ex[i]) $display("FAIL directed%0d_result: got %h expected %h", i, {voted, err_a, err_b, err_c}, ex[i]);
         else n_pass++;
         step();
         model_xfer(ex[i]);
         n_total++;
         if ({cnt_a, cnt_b, cnt_c} !== exp_cnts() || in_ready !== 1'b1) $display("FAIL directed%0d_cnt: got %h rdy %b expected %h rdy 1", i, {cnt_a, cnt_b, cnt_c}, in_ready, exp_cnts());
         else n_pass++;
      end
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int               lat;
      logic [WIDTH+2:0] ex;
      ex        = {8'h00, 3'b010};
      out_ready = 1'b0;
      send_word(8'h00, 8'h3C, 8'h00, lat);
      n_total++;
      if (lat != WIDTH) $display("FAIL bp_latency: got %0d expected %0d", lat, WIDTH);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         ch_a     = 8'($urandom);
         ch_b     = 8'($urandom);
         ch_c     = 8'($urandom);
         in_valid = 1'b1;
         step();
         n_total++;
         if ({out_valid, in_ready, busy, voted, err_a, err_b, err_c} !== {3'b101, ex} || {cnt_a, cnt_b, cnt_c} !== exp_cnts())
            $display("FAIL bp_hold%0d: got %b_%h cnt %h expected 101_%h cnt %h", i, {out_valid, in_ready, busy}, {voted, err_a, err_b, err_c}, {cnt_a, cnt_b, cnt_c}, ex, exp_cnts());
         else n_pass++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      model_xfer(ex);
      out_ready = 1'b0;
      n_total++;
      if ({cnt_a, cnt_b, cnt_c} !== exp_cnts() || {in_ready, out_valid} !== 2'b10) $display("FAIL bp_xfer: got cnt %h hs %b expected cnt %h hs 10", {cnt_a, cnt_b, cnt_c}, {in_ready, out_valid}, exp_cnts());
      else n_pass++;
      step();
      n_total++;
      if ({in_ready, busy, out_valid} !== 3'b100) $display("FAIL bp_ignored_words: got %b expected 100", {in_ready, busy, out_valid});
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int lat;
      ch_a      = 8'($urandom);
      ch_b      = 8'($urandom);
      ch_c      = 8'($urandom);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) step();
      n_total++;
      if ({in_ready, busy, out_valid} !== 3'b010) $display("FAIL mid_vote_hs: got %b expected 010", {in_ready, busy, out_valid});
      else n_pass++;
      rst = 1'b1;
      step();
      rst   = 1'b0;
      exp_a = 0;
      exp_b = 0;
      exp_c = 0;
      n_total++;
      if ({in_ready, busy, out_valid, voted, err_a, err_b, err_c, cnt_a, cnt_b, cnt_c} !== {3'b100, {(WIDTH + 3 + 3 * CNT_W){1'b0}}})
         $display("FAIL mid_reset: got %b_%h_%h expected 100_0_0", {in_ready, busy, out_valid}, {voted, err_a, err_b, err_c}, {cnt_a, cnt_b, cnt_c});
      else n_pass++;
      send_word(8'h55, 8'h55, 8'hAA, lat);
      n_total++;
      if (lat != WIDTH || {voted, err_a, err_b, err_c} !== {8'h55, 3'b001}) $display("FAIL post_reset_word: got lat %0d %h expected lat %0d %h", lat, {voted, err_a, err_b, err_c}, WIDTH, {8'h55, 3'b001});
      else n_pass++;
      step();
      model_xfer({8'h55, 3'b001});
      out_ready = 1'b0;
      n_total++;
      if ({cnt_a, cnt_b, cnt_c} !== exp_cnts()) $display("FAIL post_reset_cnt: got %h expected %h", {cnt_a, cnt_b, cnt_c}, exp_cnts());
      else n_pass++;
   endtask

   task automatic test_saturation();
      int               lat;
      logic [WIDTH-1:0] r, m;
      apply_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         r = 8'($urandom);
         m = 8'($urandom_range(1, 255));
         send_word(r, r ^ m, r, lat);
         n_total++;
         if (lat != WIDTH || {voted, err_a, err_b, err_c} !== {r, 3'b010}) $display("FAIL sat%0d_result: got lat %0d %h expected lat %0d %h", k, lat, {voted, err_a, err_b, err_c}, WIDTH, {r, 3'b010});
         else n_pass++;
         step();
         model_xfer({r, 3'b010});
         n_total++;
         if ({cnt_a, cnt_b, cnt_c} !== {2'd0, 2'((k < 3) ? k + 1 : 3), 2'd0}) $display("FAIL sat%0d_cnt: got %h expected b=%0d only", k, {cnt_a, cnt_b, cnt_c}, (k < 3) ? k + 1 : 3);
         else n_pass++;
      end
      out_ready = 1'b0;
   endtask

`ifdef MAJ_VOTE_CNT_CLR_EN
   task automatic test_cnt_clr();
      int lat;
      out_ready = 1'b0;
      send_word(8'h00, 8'hFF, 8'h00, lat);
      n_total++;
      if (cnt_b !== 2'd3 || err_b !== 1'b1) $display("FAIL clr_setup: got cnt_b %0d err_b %b expected 3 1", cnt_b, err_b);
      else n_pass++;
      cnt_clr   = 1'b1;
      out_ready = 1'b1;
      step();
      cnt_clr   = 1'b0;
      out_ready = 1'b0;
      exp_a = 0;
      exp_b = 0;
      exp_c = 0;
      n_total++;
      if ({cnt_a, cnt_b, cnt_c} !== '0) $display("FAIL clr_priority: got %h expected 0", {cnt_a, cnt_b, cnt_c});
      else n_pass++;
   endtask
`endif

   task automatic test_random();
      int               lat, dly, mode;
      logic [WIDTH-1:0] a, b, c, r, m;
      logic [WIDTH+2:0] ex;
      for (int n = 0; n < 30; n++) begin
         r    = 8'($urandom);
         m    = 8'($urandom_range(1, 255));
         mode = $urandom_range(0, 4);
         a = r; b = r; c = r;
         case (mode)
            1: a = r ^ m;
            2: b = r ^ m;
            3: c = r ^ m;
            4: begin a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); end
            default: ;
         endcase
         ex        = expect_result(a, b, c);
         out_ready = 1'b0;
         send_word(a, b, c, lat);
         dly = $urandom_range(0, 3);
         for (int i = 0; i < dly; i++) step();
         n_total++;
         if (lat != WIDTH || out_valid !== 1'b1 || {voted, err_a, err_b, err_c} !== ex)
            $display("FAIL rand%0d_result: got lat %0d ov %b %h expected lat %0d ov 1 %h", n, lat, out_valid, {voted, err_a, err_b, err_c}, WIDTH, ex);
         else n_pass++;
         out_ready = 1'b1;
         step();
         model_xfer(ex);
         n_total++;
         if ({cnt_a, cnt_b, cnt_c} !== exp_cnts()) $display("FAIL rand%0d_cnt: got %h expected %h", n, {cnt_a, cnt_b, cnt_c}, exp_cnts());
         else n_pass++;
      end
      out_ready = 1'b0;
   endtask

   // in_valid and out_ready held high: accepts must be exactly WIDTH+2 cycles apart, never overlapping a transfer.
   task automatic test_back_to_back();
      logic [WIDTH+2:0] q[$];
      logic [WIDTH+2:0] popped;
      int  cyc, last_acc, n_acc;
      bit  acc_now, xfer_now;
      apply_reset();
      cyc = 0; last_acc = -1; n_acc = 0;
      out_ready = 1'b1;
      ch_a = 8'($urandom); ch_b = 8'($urandom); ch_c = 8'($urandom);
      in_valid = 1'b1;
      while ((n_acc < 5 || q.size() > 0) && cyc < 300) begin
         acc_now  = 1'b0;
         xfer_now = 1'b0;
         n_total++;
         if (in_ready === 1'b1 && out_valid === 1'b1) $display("FAIL b2b_overlap: cycle %0d in_ready and out_valid both 1", cyc);
         else n_pass++;
         if (out_valid === 1'b1) begin
            n_total++;
            if (q.size() == 0 || {voted, err_a, err_b, err_c} !== q[0]) $display("FAIL b2b_result: got %h expected %h", {voted, err_a, err_b, err_c}, (q.size() > 0) ? q[0] : '0);
            else n_pass++;
            xfer_now = 1'b1;
         end
         if (in_ready === 1'b1 && in_valid) begin
            if (last_acc >= 0) begin
               n_total++;
               if (cyc - last_acc != WIDTH + 2) $display("FAIL b2b_interval: got %0d expected %0d", cyc - last_acc, WIDTH + 2);
               else n_pass++;
            end
            last_acc = cyc;
            q.push_back(expect_result(ch_a, ch_b, ch_c));
            n_acc++;
            acc_now = 1'b1;
         end
         step();
         cyc++;
         if (xfer_now && q.size() > 0) begin
            popped = q.pop_front();
            model_xfer(popped);
            n_total++;
            if ({cnt_a, cnt_b, cnt_c} !== exp_cnts()) $display("FAIL b2b_cnt: got %h expected %h", {cnt_a, cnt_b, cnt_c}, exp_cnts());
            else n_pass++;
         end
         if (acc_now) begin
            ch_a = 8'($urandom); ch_b = 8'($urandom); ch_c = 8'($urandom);
            if (n_acc >= 5) in_valid = 1'b0;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      n_total++;
      if (cyc >= 300) $display("FAIL b2b_timeout: got %0d cycles expected under 300", cyc);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_saturation();
`ifdef MAJ_VOTE_CNT_CLR_EN
      test_cnt_clr();
`endif
      test_random();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation watchdog expired");
   end

endmodule

// File: doc/maj_vote_seq.md
Name: maj_vote_seq

Overview:
- Bit-serial triple-redundancy voting controller built around a single 3-input majority function, d = (a|b)&(a|c)&(b|c).
- Accepts three WIDTH-bit channel words, sequences them one bit per cycle through the majority unit and assembles the voted word.
- Flags each channel that disagreed with the vote and keeps saturating per-channel fault counters.
- Sits between redundant sources and downstream consumers.

Parameters:
WIDTH, 8, bits per channel word; minimum 2.
CNT_W, 8, width of each per-channel fault counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous active-high reset.
in_valid  input  1  channel words present.
in_ready  output  1  block can accept words; high only in IDLE.
ch_a  input  WIDTH  channel A word.
ch_b  input  WIDTH  channel B word.
ch_c  input  WIDTH  channel C word.
out_valid  output  1  voted result available; high only in DONE.
out_ready  input  1  consumer accepts result.
voted  output  WIDTH  voted word, registered.
err_a  output  1  channel A differed from vote in at least one bit of this word.
err_b  output  1  same for channel B.
err_c  output  1  same for channel C.
cnt_a  output  CNT_W  words with err_a, saturating.
cnt_b  output  CNT_W  same for channel B.
cnt_c  output  CNT_W  same for channel C.
busy  output  1  high in VOTE or DONE.

Behaviour:
- Interface: one clock (clk); synchronous, active-high reset (rst).
- Reset: the following all take value 0 at the next edge with rst high:
  - state → IDLE
  - shift registers, bit index
  - voted, err_a/b/c, cnt_a/b/c
- Outputs after reset: in_ready=1, out_valid=0, busy=0.
- rst overrides all other inputs, including mid-VOTE and mid-DONE; no partial result survives.
- FSM states: IDLE, VOTE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture ch_a/b/c into shift registers sa/sb/sc, clear voted and err flags, idx=0, go to VOTE.
- VOTE, one bit per cycle, LSB first:
  - m = maj(sa[0],sb[0],sc[0]).
  - voted[idx] <= m.
  - err_x <= err_x | (sx[0]^m) for each channel x.
  - Shift sa/sb/sc right by one; idx++.
  - When idx = WIDTH-1 is processed, go to DONE.
  - VOTE lasts exactly WIDTH cycles.
  - in_valid is ignored (in_ready=0).
- DONE:
  - out_valid=1; voted and err_a/b/c held stable.
  - On out_valid & out_ready: increment cnt_x for each err_x set, saturating at 2^CNT_W-1, then go to IDLE.
  - Without out_ready, DONE holds indefinitely.
- Latency: out_valid rises WIDTH cycles after the accepting edge.
  - Throughput: one word per WIDTH+2 cycles, minimum.
  - There is no overlap: no accept occurs in the same cycle as a result transfer.
- Flag combinations:
  - Per bit, at most one channel can disagree.
  - Across a word, any combination of err_a/b/c is legal, including all three.
- Output validity: voted/err_x are meaningful only while out_valid=1. Counters are always valid.
- Width rules:
  - idx is ceil(log2(WIDTH)) bits.
  - Counters never wrap.

Optional Feature:
Macro MAJ_VOTE_CNT_CLR_EN.
- Defined: adds input port cnt_clr (1 bit).
  - cnt_clr high at an edge synchronously zeroes cnt_a/b/c.
  - cnt_clr has priority over a same-cycle increment; that increment is lost.
  - FSM, voted and err flags are unaffected.
- Undefined: no cnt_clr port; counters clear only on rst.

Test Plan:
1. ch_a=ch_b=ch_c=0xA5, out_ready=1 → out_valid 8 cycles after accept; voted=0xA5; err_a/b/c=0; counters stay 0.
2. ch_a=0xFF, ch_b=0x0F, ch_c=0xF0 → voted=0xFF; err_a=0, err_b=1, err_c=1; after transfer cnt_b=1, cnt_c=1, cnt_a=0.
3. Backpressure: ch_a=0x00, ch_b=0x3C, ch_c=0x00, out_ready low 5 cycles after out_valid, in_valid pulsed with new words meanwhile → voted=0x00 and err_b=1 held stable; in_ready=0; new words ignored; cnt_b increments once, only on the out_ready cycle.
4. Reset mid-operation: rst asserted during VOTE at idx=3 → next cycle state IDLE, in_ready=1, busy=0, voted=0, all err/cnt=0; then words 0x55/0x55/0xAA → voted=0x55, err_c=1.
5. Saturation: CNT_W=2, five consecutive words with only ch_b faulty → cnt_b sequence 1,2,3,3,3; cnt_a=cnt_c=0.
6. With MAJ_VOTE_CNT_CLR_EN: cnt_b=3, cnt_clr asserted in the same cycle as a faulty-b transfer → cnt_b=0, not 1. Without macro: build elaborates with no cnt_clr port.
